// File: rtl/jk_bank_sequencer_if.sv
// Host handshake plus JK bank drive/feedback bundle for jk_bank_sequencer.
// slave = sequencer side, master = host/bank side.
interface jk_bank_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             START;
    logic             DIR;
    logic [WIDTH-1:0] MODULUS;
    logic             ABORT;
    logic [WIDTH-1:0] Q_FB;
    logic [WIDTH-1:0] J;
    logic [WIDTH-1:0] K;
    logic             BUSY;
    logic             DONE;
    logic             ERR;

    modport slave (
        input  START, DIR, MODULUS, ABORT, Q_FB,
        output J, K, BUSY, DONE, ERR
    );

    modport master (
        output START, DIR, MODULUS, ABORT, Q_FB,
        input  J, K, BUSY, DONE, ERR
    );
endinterface

// File: rtl/jk_bank_sequencer.sv
// Drives a JK flip-flop bank as a mod-M up/down counter and checks its Q.
// Optional macro JK_TOGGLE_EN: count steps use J=K=1 toggle encoding.
module jk_bank_sequencer #(
    parameter int WIDTH = 4
) (
    input logic CLK,
    input logic CLR,
    jk_bank_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] exp_nxt;
    logic [WIDTH-1:0] m_q;
    logic             dir_q;
    logic             done_q;
    logic             done_nxt;
    logic             err_q;
    logic             err_nxt;
    logic             latch;
    logic             drive;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] j_c;
    logic [WIDTH-1:0] k_c;

    assign q = bus.Q_FB;
    // M=0 wraps to all ones, which is exactly 2^WIDTH-1.
    assign term = dir_q ? '0 : (m_q - ONE);

    always_comb begin
        state_nxt = state;
        exp_nxt   = exp_q;
        done_nxt  = 1'b0;
        err_nxt   = err_q;
        latch     = 1'b0;
        drive     = 1'b0;
        target    = q;
        unique case (1'b1)
            (state == IDLE): begin
                if (bus.START) begin
                    latch     = 1'b1;
                    err_nxt   = 1'b0;
                    state_nxt = LOAD;
                end
            end
            (state == LOAD): begin
                if (bus.ABORT) begin
                    state_nxt = IDLE;
                end else begin
                    target    = dir_q ? (m_q - ONE) : '0;
                    drive     = 1'b1;
                    exp_nxt   = target;
                    state_nxt = RUN;
                end
            end
            (state == RUN): begin
                if (bus.ABORT) begin
                    state_nxt = IDLE;
                end else if (q != exp_q) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (q == term) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    target  = dir_q ? (q - ONE) : (q + ONE);
                    drive   = 1'b1;
                    exp_nxt = target;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        j_c = '0;
        k_c = '0;
        if (CLR) begin
            k_c = '1;
        end else if (drive) begin
`ifdef JK_TOGGLE_EN
            // Loads keep set/clear form: a toggle depends on the current Q.
            if (state == RUN) begin
                j_c = target ^ q;
                k_c = target ^ q;
            end else begin
                j_c = target & ~q;
                k_c = ~target & q;
            end
`else
            j_c = target & ~q;
            k_c = ~target & q;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state  <= IDLE;
            exp_q  <= '0;
            m_q    <= '0;
            dir_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            exp_q  <= exp_nxt;
            done_q <= done_nxt;
            err_q  <= err_nxt;
            if (latch) begin
                m_q   <= bus.MODULUS;
                dir_q <= bus.DIR;
            end
        end
    end

    assign bus.J    = j_c;
    assign bus.K    = k_c;
    assign bus.BUSY = (state == LOAD) || (state == RUN);
    assign bus.DONE = done_q;
    assign bus.ERR  = err_q;
endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Scoreboard bench for jk_bank_sequencer with a behavioural JK bank model.
// Build with +define+JK_TOGGLE_EN to check the toggle-encoding variant.
module tb_jk_bank_sequencer;
    localparam int W = 4;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    jk_bank_sequencer_if #(.WIDTH(W)) bus ();

    jk_bank_sequencer #(.WIDTH(W)) dut (
        .CLK(clk),
        .CLR(clr),
        .bus(bus)
    );

    logic [W-1:0] bank_q;
    logic [W-1:0] inj;
    logic [W-1:0] pre_val;
    logic         pre_en;

    function automatic logic [W-1:0] jk_step(
        input logic [W-1:0] qv,
        input logic [W-1:0] jv,
        input logic [W-1:0] kv
    );
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            case ({jv[i], kv[i]})
                2'b00:   r[i] = qv[i];
                2'b01:   r[i] = 1'b0;
                2'b10:   r[i] = 1'b1;
                default: r[i] = ~qv[i];
            endcase
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (pre_en) bank_q <= pre_val;
        else        bank_q <= jk_step(bank_q, bus.J, bus.K);
    end

    assign bus.Q_FB = bank_q | inj;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    int exp_done[$];
    logic busy_prev = 1'b0;
    logic run_dir = 1'b0;

    task automatic chk(input string nm, input int act, input int req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: RUN cycles are busy cycles preceded by a busy cycle.
    always @(negedge clk) begin
        #2;
        if (!clr) begin
            if (bus.BUSY && busy_prev) begin
                if (exp_q.size() == 0) chk("q_unexpected", int'(bus.Q_FB), -1);
                else chk("q_trace", int'(bus.Q_FB), exp_q.pop_front());
`ifdef JK_TOGGLE_EN
                if (!run_dir && bus.Q_FB == 4'd3 && inj == '0) begin
                    chk("toggle_j_3to4", int'(bus.J), 7);
                    chk("toggle_k_3to4", int'(bus.K), 7);
                end
`endif
            end
            if (bus.DONE) begin
                if (exp_done.size() == 0) chk("done_unexpected", cyc, -1);
                else chk("done_cycle", cyc, exp_done.pop_front());
            end
`ifndef JK_TOGGLE_EN
            chk("jk_overlap", int'(bus.J & bus.K), 0);
`endif
        end
        busy_prev = bus.BUSY;
    end

    task automatic start_run(input logic [W-1:0] m, input logic d, input logic abt,
                             output int e);
        @(negedge clk);
        bus.START   = 1'b1;
        bus.ABORT   = abt;
        bus.MODULUS = m;
        bus.DIR     = d;
        run_dir     = d;
        @(posedge clk);
        #1;
        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        e = cyc;
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #3;
            if (!bus.BUSY) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic wait_q(input int v, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.BUSY && busy_prev && int'(bus.Q_FB) == v) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("q_wait_timeout", 0, 1);
    endtask

    initial begin
        int e;
        clr         = 1'b1;
        pre_en      = 1'b1;
        pre_val     = 4'b1011;
        inj         = '0;
        bus.START   = 1'b0;
        bus.ABORT   = 1'b0;
        bus.DIR     = 1'b0;
        bus.MODULUS = '0;

        @(posedge clk);
        #1 pre_en = 1'b0;
        // Bank holds 1011; two reset edges must clear it through K.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", int'(bus.Q_FB), 0);
        chk("rst_j", int'(bus.J), 0);
        chk("rst_k", int'(bus.K), 15);
        chk("rst_busy", int'(bus.BUSY), 0);
        chk("rst_done", int'(bus.DONE), 0);
        chk("rst_err", int'(bus.ERR), 0);
        @(negedge clk);
        clr = 1'b0;

        // Up, M=5: 0..4, DONE in cycle e+7 (seen after edge e+6).
        start_run(4'd5, 1'b0, 1'b0, e);
        chk("busy_load", int'(bus.BUSY), 1);
        exp_q = '{0, 1, 2, 3, 4};
        exp_done.push_back(e + 6);
        wait_idle(30);
        repeat (2) @(negedge clk);
        chk("hold_after_done", int'(bus.Q_FB), 4);

        // Down, M=5: 4..0.
        start_run(4'd5, 1'b1, 1'b0, e);
        exp_q = '{4, 3, 2, 1, 0};
        exp_done.push_back(e + 6);
        wait_idle(30);

        // M=0 up: 16 values, DONE in cycle e+18.
        start_run(4'd0, 1'b0, 1'b0, e);
        for (int i = 0; i < 16; i++) exp_q.push_back(i);
        exp_done.push_back(e + 17);
        wait_idle(40);

        // M=1 up: single RUN cycle at 0.
        start_run(4'd1, 1'b0, 1'b0, e);
        exp_q = '{0};
        exp_done.push_back(e + 2);
        wait_idle(20);

        // ABORT while Q=2: no DONE, bank holds.
        start_run(4'd5, 1'b0, 1'b0, e);
        exp_q = '{0, 1, 2};
        wait_q(2, 20);
        bus.ABORT = 1'b1;
        #1;
        chk("abort_j", int'(bus.J), 0);
        chk("abort_k", int'(bus.K), 0);
        @(posedge clk);
        #1 bus.ABORT = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(bus.BUSY), 0);
        chk("abort_q_hold", int'(bus.Q_FB), 2);
        chk("abort_err", int'(bus.ERR), 0);

        // START with ABORT in IDLE: START wins. Then corrupt Q 3 -> 7.
        start_run(4'd5, 1'b0, 1'b1, e);
        chk("start_wins", int'(bus.BUSY), 1);
        exp_q = '{0, 1, 2, 7};
        wait_q(2, 20);
        @(negedge clk);
        chk("pre_inject_q", int'(bank_q), 3);
        inj = 4'b0100;
        @(posedge clk);
        #1 inj = '0;
        @(negedge clk);
        chk("err_set", int'(bus.ERR), 1);
        chk("err_busy", int'(bus.BUSY), 0);
        chk("err_q_hold", int'(bus.Q_FB), 3);
        repeat (2) @(negedge clk);
        chk("err_sticky", int'(bus.ERR), 1);

        start_run(4'd5, 1'b0, 1'b0, e);
        chk("err_cleared", int'(bus.ERR), 0);
        exp_q = '{0, 1, 2, 3, 4};
        exp_done.push_back(e + 6);
        wait_idle(30);
        repeat (3) @(negedge clk);

        chk("q_queue_drained", exp_q.size(), 0);
        chk("done_queue_drained", exp_done.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
